// File: rtl/fe_fetch_stage.sv
// Fetch stage of the RV32 in-order pipeline: drives the FE latch and keeps one imem request in flight.
// Defining FE_PERF_CNT_EN adds the perf_stall_cycles / perf_squash_cnt counter outputs.
module fe_fetch_stage #(
   parameter int unsigned         DBITS      = 32,
   parameter int unsigned         INSTBITS   = 32,
   parameter int unsigned         CANARY_W   = 4,
   parameter logic [CANARY_W-1:0] CANARY_VAL = 4'hF,
   parameter logic [DBITS-1:0]    START_PC   = '0
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 from_DE_to_FE,
   input  logic                                 br_redirect_AGEX,
   input  logic [DBITS-1:0]                     br_target_AGEX,
   output logic                                 imem_req,
   output logic [DBITS-1:0]                     imem_addr,
   input  logic                                 imem_ready,
   input  logic                                 imem_rvalid,
   input  logic [INSTBITS-1:0]                  imem_rdata,
`ifdef FE_PERF_CNT_EN
   output logic [31:0]                          perf_stall_cycles,
   output logic [31:0]                          perf_squash_cnt,
`endif
   output logic [INSTBITS+3*DBITS+CANARY_W-1:0] FE_latch_out
);

   localparam int unsigned LW = INSTBITS + 3*DBITS + CANARY_W;

   typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_HOLD} state_e;

   state_e              state_q, state_d;
   logic [DBITS-1:0]    pc_q, pc_d;
   logic [DBITS-1:0]    cnt_q, cnt_d;
   logic [LW-1:0]       latch_q, latch_d;
   logic [INSTBITS-1:0] buf_q, buf_d;
   logic                squash_q, squash_d;

   logic                rsp_ok;
   logic                load;
   logic [INSTBITS-1:0] load_inst;
   logic [DBITS-1:0]    pc_plus4;
   logic [DBITS-1:0]    redir_pc;

   // A response is usable only if no redirect has overtaken it.
   assign rsp_ok    = (state_q == ST_WAIT) && imem_rvalid && !squash_q && !br_redirect_AGEX;
   assign load      = !br_redirect_AGEX && !from_DE_to_FE &&
                      (rsp_ok || (state_q == ST_HOLD));
   assign load_inst = (state_q == ST_HOLD) ? buf_q : imem_rdata;
   assign pc_plus4  = pc_q + DBITS'(4);
   assign redir_pc  = br_target_AGEX & ~DBITS'(3);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_REQ;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_REQ: begin
            if (!br_redirect_AGEX && imem_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               if (squash_q || br_redirect_AGEX || !from_DE_to_FE) state_d = ST_REQ;
               else                                                state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (br_redirect_AGEX || !from_DE_to_FE) state_d = ST_REQ;
         end
         default: state_d = ST_REQ;
      endcase
   end

   always_comb begin
      imem_req  = reset && (state_q == ST_REQ) && !br_redirect_AGEX;
      imem_addr = pc_q;
   end

   always_comb begin
      pc_d     = pc_q;
      cnt_d    = cnt_q;
      latch_d  = latch_q;
      buf_d    = buf_q;
      squash_d = squash_q;
      if (state_q == ST_WAIT) begin
         if (imem_rvalid)           squash_d = 1'b0;
         else if (br_redirect_AGEX) squash_d = 1'b1;
      end
      if (rsp_ok && from_DE_to_FE) buf_d = imem_rdata;
      if (br_redirect_AGEX) begin
         pc_d    = redir_pc;
         latch_d = '0;
      end else if (load) begin
         latch_d = {load_inst, pc_q, pc_plus4, cnt_q, CANARY_VAL};
         pc_d    = pc_plus4;
         cnt_d   = cnt_q + DBITS'(1);
      end else if (!from_DE_to_FE) begin
         latch_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q     <= START_PC;
         cnt_q    <= '0;
         latch_q  <= '0;
         buf_q    <= '0;
         squash_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         cnt_q    <= cnt_d;
         latch_q  <= latch_d;
         buf_q    <= buf_d;
         squash_q <= squash_d;
      end
   end

   assign FE_latch_out = latch_q;

`ifdef FE_PERF_CNT_EN
   logic [31:0] stall_cnt_q, squash_cnt_q;
   logic        discard;

   assign discard = ((state_q == ST_WAIT) && imem_rvalid && (squash_q || br_redirect_AGEX)) ||
                    ((state_q == ST_HOLD) && br_redirect_AGEX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q  <= '0;
         squash_cnt_q <= '0;
      end else begin
         if (from_DE_to_FE) stall_cnt_q  <= stall_cnt_q + 32'd1;
         if (discard)       squash_cnt_q <= squash_cnt_q + 32'd1;
      end
   end

   assign perf_stall_cycles = stall_cnt_q;
   assign perf_squash_cnt   = squash_cnt_q;
`endif

endmodule

// File: tb/tb_fe_fetch_stage.sv
// Bench for fe_fetch_stage: directed test-plan steps then random traffic against a transaction-level model.
module tb_fe_fetch_stage;
   localparam int unsigned LW = 32 + 3*32 + 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          stall = 1'b0;
   logic          redir = 1'b0;
   logic [31:0]   target = '0;
   logic          imem_req;
   logic [31:0]   imem_addr;
   logic          imem_ready = 1'b0;
   logic          imem_rvalid = 1'b0;
   logic [31:0]   imem_rdata = '0;
   logic [LW-1:0] latch;
`ifdef FE_PERF_CNT_EN
   logic [31:0]   perf_stall_cycles, perf_squash_cnt;
`endif

   always #5 clk = ~clk;

   fe_fetch_stage dut (
      .clk              (clk),
      .reset            (rst_n),
      .from_DE_to_FE    (stall),
      .br_redirect_AGEX (redir),
      .br_target_AGEX   (target),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_ready       (imem_ready),
      .imem_rvalid      (imem_rvalid),
      .imem_rdata       (imem_rdata),
`ifdef FE_PERF_CNT_EN
      .perf_stall_cycles(perf_stall_cycles),
      .perf_squash_cnt  (perf_squash_cnt),
`endif
      .FE_latch_out     (latch)
   );

   int total = 0;
   int bad   = 0;

   // Memory model: one transaction in flight, stale if a redirect overtook it.
   bit          m_out, m_stale;
   logic [31:0] m_addr;
   int          m_lat;
   int          lat_lo = 0, lat_hi = 0;
   // Fetch model: an instruction waiting for decode, and the next expected latch contents.
   bit          m_pend;
   logic [31:0] m_pinst;
   logic [31:0] e_pc, e_cnt;
   logic [LW-1:0] e_latch;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
   endfunction

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic ref_reset();
      m_out = 0; m_stale = 0; m_lat = 0; m_addr = '0;
      m_pend = 0; m_pinst = '0;
      e_pc = 32'h0; e_cnt = 32'h0; e_latch = '0;
   endtask

   task automatic cyc(input bit s, input bit r, input logic [31:0] t, input bit rdy, input bit spur);
      bit          p_req, p_rv, exp_req;
      logic [31:0] p_addr, p_data;
      stall = s; redir = r; target = t; imem_ready = rdy;
      p_rv = 0; p_data = $urandom;
      if (m_out && m_lat == 0) begin
         p_rv = 1; p_data = memfn(m_addr);
      end else if (!m_out && spur) p_rv = 1;
      imem_rvalid = p_rv; imem_rdata = p_data;
      #1;
      exp_req = !m_out && !m_pend && !r;
      chk("imem_req", imem_req, exp_req);
      if (exp_req) chk("imem_addr", imem_addr, e_pc);
      p_req = imem_req; p_addr = imem_addr;
      @(posedge clk); #1;
      if (p_rv && m_out) begin
         m_out = 0;
         if (!m_stale && !r) begin m_pend = 1; m_pinst = p_data; end
      end
      if (m_out) begin
         if (r) m_stale = 1;
         if (m_lat > 0) m_lat--;
      end
      if (p_req && rdy) begin
         m_out = 1; m_stale = 0; m_addr = p_addr;
         m_lat = $urandom_range(lat_hi, lat_lo);
      end
      if (r) begin
         m_pend = 0; e_latch = '0; e_pc = {t[31:2], 2'b00};
      end else if (m_pend && !s) begin
         e_latch = {m_pinst, e_pc, e_pc + 32'd4, e_cnt, 4'hF};
         e_pc = e_pc + 32'd4; e_cnt = e_cnt + 32'd1; m_pend = 0;
      end else if (!s) e_latch = '0;
      chk("latch", latch, e_latch);
   endtask

   task automatic quiet();
      stall = 0; redir = 0; imem_rvalid = 0; imem_ready = 1;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 0; stall = 0; redir = 0; imem_rvalid = 0; imem_ready = 0;
      #1;
      chk("req_in_reset", imem_req, 1'b0);
      chk("latch_in_reset", latch, '0);
      @(posedge clk); #1;
      chk("req_in_reset_edge", imem_req, 1'b0);
      @(negedge clk);
      rst_n = 1;
      ref_reset();
   endtask

   initial begin
      ref_reset();
      do_reset();

      // First fetch from START_PC with a zero-wait memory.
      cyc(0, 0, '0, 1, 0);
      cyc(0, 0, '0, 1, 0);
      chk("t1_first_latch", latch, {32'h0050_0093, 32'h0, 32'h4, 32'h0, 4'hF});
      quiet();
      chk("t1_next_req", imem_req, 1'b1);
      chk("t1_next_addr", imem_addr, 32'h4);

      // Stall holds the latch; the buffered instruction lands when it drops.
      cyc(0, 0, '0, 1, 0);
      cyc(0, 0, '0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, '0, 1, 0);
         chk("t2_held_cnt", latch[35:4], 32'd1);
         chk("t2_held_pc", latch[99:68], 32'h4);
      end
      cyc(0, 0, '0, 1, 0);
      chk("t2_cnt2", latch[35:4], 32'd2);
      chk("t2_pc8", latch[99:68], 32'h8);

      // Redirect while waiting on a slow response.
      lat_lo = 2; lat_hi = 2;
      cyc(0, 0, '0, 1, 0);
      cyc(0, 1, 32'h0000_0103, 1, 0);
      cyc(0, 0, '0, 1, 0);
      cyc(0, 0, '0, 1, 0);
      chk("t3_bubble", latch, '0);
      quiet();
      chk("t3_req", imem_req, 1'b1);
      chk("t3_addr", imem_addr, 32'h100);
      lat_lo = 0; lat_hi = 0;

      // Redirect in HOLD with a stray rvalid.
      cyc(0, 0, '0, 1, 0);
      cyc(1, 0, '0, 1, 0);
      cyc(1, 1, 32'h0000_0200, 1, 1);
      chk("t4_latch_zero", latch, '0);
      quiet();
      chk("t4_req", imem_req, 1'b1);
      chk("t4_addr", imem_addr, 32'h200);

      // Reset mid-transaction at PC 0x40.
      cyc(0, 1, 32'h0000_0040, 1, 0);
      lat_lo = 3; lat_hi = 3;
      cyc(0, 0, '0, 1, 0);
      cyc(0, 0, '0, 1, 0);
      do_reset();
      lat_lo = 0; lat_hi = 0;
      quiet();
      chk("t5_req", imem_req, 1'b1);
      chk("t5_addr", imem_addr, 32'h0);
      cyc(0, 0, '0, 1, 0);
      cyc(0, 0, '0, 1, 0);
      chk("t5_refetch", latch, {32'h0050_0093, 32'h0, 32'h4, 32'h0, 4'hF});

      // PC wrap at the top of the address space.
      cyc(0, 1, 32'hFFFF_FFFE, 1, 0);
      cyc(0, 0, '0, 1, 0);
      cyc(0, 0, '0, 1, 0);
      chk("t6_pc", latch[99:68], 32'hFFFF_FFFC);
      chk("t6_pcplus", latch[67:36], 32'h0);
      quiet();
      chk("t6_next_addr", imem_addr, 32'h0);

      // Random traffic.
      lat_lo = 0; lat_hi = 3;
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] t;
         t = ($urandom % 4 == 0) ? (32'hFFFF_FFF8 | ($urandom % 8)) : $urandom;
         if (i == 1500) do_reset();
         cyc(($urandom % 100) < 30, ($urandom % 100) < 5, t,
             ($urandom % 100) < 75, ($urandom % 100) < 20);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
